// File: rtl/usb_edge_filter.sv
// Glitch-filtered, multi-channel edge detector for the USB 1.1 receive path.
// Each channel debounces its input, pulses on qualified edges and keeps a saturating edge count.
module usb_edge_filter #(
    parameter int   NUM_CH     = 2,
    parameter int   FILTER_LEN = 2,
    parameter int   CNT_W      = 8,
    parameter logic RST_LVL    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    cnt_clr,
    input  logic [NUM_CH-1:0]       din,
    output logic [NUM_CH-1:0]       level,
    output logic [NUM_CH-1:0]       d_edge,
    output logic                    any_edge,
    output logic [NUM_CH*CNT_W-1:0] edge_cnt
);

    localparam int SW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [SW-1:0]    STAB_MAX = SW'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SW-1:0]    stab_cnt [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [NUM_CH-1:0] level_q;
    logic [NUM_CH-1:0] edge_q;
    logic [NUM_CH-1:0] trans;
    logic [NUM_CH-1:0] qual;

    // A transition fires on the sample that completes FILTER_LEN differing samples;
    // its direction is implied by the current level (1 means falling).
    always_comb begin
        trans = '0;
        qual  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            trans[i] = (din[i] != level_q[i]) && (stab_cnt[i] == STAB_MAX);
            if (en && trans[i]) begin
                case (mode)
                    2'b00:   qual[i] = level_q[i];
                    2'b01:   qual[i] = ~level_q[i];
                    2'b10:   qual[i] = 1'b1;
                    default: qual[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= {NUM_CH{RST_LVL}};
            edge_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                stab_cnt[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            edge_q <= qual;
            for (int i = 0; i < NUM_CH; i++) begin
                if (din[i] == level_q[i]) begin
                    stab_cnt[i] <= '0;
                end else if (trans[i]) begin
                    level_q[i]  <= din[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + SW'(1);
                end

                // A clear coinciding with a qualified edge leaves that edge counted.
                if (cnt_clr) begin
                    cnt_q[i] <= qual[i] ? CNT_W'(1) : '0;
                end else if (qual[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign edge_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign level    = level_q;
    assign d_edge   = edge_q;
    assign any_edge = |edge_q;

endmodule

// File: tb/tb_usb_edge_filter.sv
// Directed bench for usb_edge_filter: reset, filtering, glitches, polarity modes,
// counter saturation/clear, enable gating and mid-filter reset.
module tb_usb_edge_filter;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic [1:0]              mode;
    logic                    cnt_clr;
    logic [NUM_CH-1:0]       din;
    logic [NUM_CH-1:0]       level;
    logic [NUM_CH-1:0]       d_edge;
    logic                    any_edge;
    logic [NUM_CH*CNT_W-1:0] edge_cnt;

    int checks   = 0;
    int failures = 0;
    int pulses;

    usb_edge_filter #(
        .NUM_CH    (NUM_CH),
        .FILTER_LEN(2),
        .CNT_W     (CNT_W),
        .RST_LVL   (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .cnt_clr (cnt_clr),
        .din     (din),
        .level   (level),
        .d_edge  (d_edge),
        .any_edge(any_edge),
        .edge_cnt(edge_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; cnt_clr = 1'b0; din = 2'b00;

        // Reset with inputs low: level still loads the idle level
        step(); step();
        check("rst_level", 32'(level), 32'h3);
        check("rst_edge", 32'(d_edge), 32'h0);
        check("rst_any", 32'(any_edge), 32'h0);
        check("rst_cnt", 32'(edge_cnt), 32'h00);

        din = 2'b11; rst = 1'b0; en = 1'b1; mode = 2'b00;
        step();

        // Falling edge on D+ held two samples
        din = 2'b10;
        step();
        check("fall_wait_level", 32'(level), 32'h3);
        check("fall_wait_edge", 32'(d_edge), 32'h0);
        step();
        check("fall_level", 32'(level), 32'h2);
        check("fall_edge", 32'(d_edge), 32'h1);
        check("fall_any", 32'(any_edge), 32'h1);
        check("fall_cnt", 32'(edge_cnt), 32'h01);
        step();
        check("fall_pulse_end", 32'(d_edge), 32'h0);

        // Rising back is not qualified in falling mode
        din = 2'b11;
        step(); step();
        check("rise_m00_level", 32'(level), 32'h3);
        check("rise_m00_edge", 32'(d_edge), 32'h0);
        check("rise_m00_cnt", 32'(edge_cnt), 32'h01);

        // One-sample glitch is rejected
        din = 2'b10;
        step();
        check("glitch_edge0", 32'(d_edge), 32'h0);
        din = 2'b11;
        step();
        check("glitch_edge1", 32'(d_edge), 32'h0);
        step();
        check("glitch_level", 32'(level), 32'h3);
        check("glitch_edge2", 32'(d_edge), 32'h0);
        check("glitch_cnt", 32'(edge_cnt), 32'h01);

        // Both-edges mode: six toggles of D- give six pulses
        mode = 2'b10;
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            din[1] = ~din[1];
            for (int c = 0; c < 4; c++) begin
                step();
                pulses += int'(d_edge[1]);
            end
        end
        check("both_pulses", 32'(pulses), 32'd6);
        check("both_cnt", 32'(edge_cnt), 32'h61);

        // Mode 11 qualifies nothing but level still tracks
        mode = 2'b11;
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            din[1] = ~din[1];
            for (int c = 0; c < 4; c++) begin
                step();
                pulses += int'(d_edge[1]) + int'(any_edge);
            end
        end
        check("none_pulses", 32'(pulses), 32'd0);
        check("none_cnt", 32'(edge_cnt), 32'h61);
        check("none_level", 32'(level), 32'h3);

        // Twenty qualified edges on D+ saturate its 4-bit counter
        mode = 2'b10;
        for (int t = 0; t < 20; t++) begin
            din[0] = ~din[0];
            step(); step(); step();
        end
        check("sat_cnt", 32'(edge_cnt), 32'h6F);

        // Clear on the same cycle as a qualified edge leaves a count of 1
        din[0] = 1'b0;
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_edge_pulse", 32'(d_edge), 32'h1);
        check("clr_edge_cnt", 32'(edge_cnt), 32'h01);

        // Clear alone
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_only_cnt", 32'(edge_cnt), 32'h00);

        // Simultaneous edges on both channels
        din = 2'b01;
        step(); step();
        check("simul_level", 32'(level), 32'h1);
        check("simul_edge", 32'(d_edge), 32'h3);
        check("simul_cnt", 32'(edge_cnt), 32'h11);
        step();

        // Disabled: level follows a falling edge, no pulse, count held
        en = 1'b0; mode = 2'b00;
        din = 2'b00;
        step(); step();
        check("dis_level", 32'(level), 32'h0);
        check("dis_edge", 32'(d_edge), 32'h0);
        check("dis_cnt", 32'(edge_cnt), 32'h11);

        // Reset mid-filter discards the partial stability count
        en = 1'b1;
        din = 2'b11;
        step();
        rst = 1'b1;
        step();
        check("midrst_level", 32'(level), 32'h3);
        check("midrst_cnt", 32'(edge_cnt), 32'h00);
        rst = 1'b0;
        din = 2'b00;
        step();
        check("post_rst_level1", 32'(level), 32'h3);
        check("post_rst_edge1", 32'(d_edge), 32'h0);
        step();
        check("post_rst_level2", 32'(level), 32'h0);
        check("post_rst_edge2", 32'(d_edge), 32'h3);
        check("post_rst_cnt", 32'(edge_cnt), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
